// File: rtl/x6_fifo_wr_ctrl_if.sv
// Handshake bundle between a six-channel producer and the x6 FIFO write controller.
// The master side produces push/clr_ovf and sees full flags; the slave side is the controller.
interface x6_fifo_wr_ctrl_if;
  logic [5:0] push;
  logic [5:0] ff_;
  logic       clr_ovf;
  logic [5:0] wren_;
  logic       fifo_rst_;
  logic       ready;
  logic [5:0] ovf;
  logic [7:0] drop_cnt;

  modport master (
    output push, ff_, clr_ovf,
    input  wren_, fifo_rst_, ready, ovf, drop_cnt
  );

  modport slave (
    input  push, ff_, clr_ovf,
    output wren_, fifo_rst_, ready, ovf, drop_cnt
  );
endinterface

// File: rtl/x6_fifo_wr_ctrl.sv
// Write controller for six external FIFOs: sequences a shared FIFO reset after init,
// then gates per-channel pushes against full flags and accounts for dropped words.
module x6_fifo_wr_ctrl #(
  parameter int unsigned RST_CYC  = 4,
  parameter int unsigned WAIT_CYC = 4
) (
  input logic                  clk,
  input logic                  init,
  x6_fifo_wr_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [3:0] RST_LAST  = 4'(RST_CYC - 1);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [5:0] wren_q;
  logic       fifo_rst_q;
  logic       ready_q;
  logic [5:0] ovf_q, ovf_nxt;
  logic [7:0] drop_cnt_q, drop_cnt_nxt;

  logic       run;
  logic [5:0] accept;
  logic [5:0] drop;
  logic [2:0] drop_num;
  logic [8:0] cnt_sum;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RST;
        cnt_nxt   = '0;
      end
    endcase
    if (init) begin
      state_nxt = ST_RST;
      cnt_nxt   = '0;
    end
  end

  // Pushes are only honoured while the registered state is RUN; full is taken as
  // sampled at the push edge and never looked at again.
  always_comb begin
    run      = (state == ST_RUN);
    accept   = run ? (bus.push & bus.ff_)  : 6'h00;
    drop     = run ? (bus.push & ~bus.ff_) : 6'h00;
    drop_num = 3'd0;
    for (int i = 0; i < 6; i++) begin
      drop_num = drop_num + 3'(drop[i]);
    end
    // A clear restarts accounting from this cycle's drops rather than losing them.
    ovf_nxt      = (bus.clr_ovf ? 6'h00 : ovf_q) | drop;
    cnt_sum      = (bus.clr_ovf ? 9'd0 : {1'b0, drop_cnt_q}) + 9'(drop_num);
    drop_cnt_nxt = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (init) begin
      state      <= ST_RST;
      cnt        <= '0;
      wren_q     <= 6'h3F;
      fifo_rst_q <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= 6'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wren_q     <= ~accept;
      fifo_rst_q <= (state_nxt != ST_RST);
      ready_q    <= (state_nxt == ST_RUN);
      ovf_q      <= ovf_nxt;
      drop_cnt_q <= drop_cnt_nxt;
    end
  end

  assign bus.wren_     = wren_q;
  assign bus.fifo_rst_ = fifo_rst_q;
  assign bus.ready     = ready_q;
  assign bus.ovf       = ovf_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_x6_fifo_wr_ctrl.sv
// Directed bench for x6_fifo_wr_ctrl: startup sequencing, writes, drops,
// saturation, clear priority and init abort, with hand-computed expectations.
module tb_x6_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic init;

  int n_checks = 0;
  int n_fail   = 0;

  x6_fifo_wr_ctrl_if bus ();

  x6_fifo_wr_ctrl #(.RST_CYC(4), .WAIT_CYC(4)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    init = 1'b1;
    bus.push = 6'h3F; bus.ff_ = 6'h3F; bus.clr_ovf = 1'b0;
    step();
    n_checks++;
    if (bus.fifo_rst_ !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rst_: got %b expected 0", bus.fifo_rst_); end
    n_checks++;
    if (bus.wren_ !== 6'h3F) begin n_fail++; $display("FAIL reset_wren_: got %b expected 111111", bus.wren_); end
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    n_checks++;
    if (bus.ovf !== 6'h00) begin n_fail++; $display("FAIL reset_ovf: got %b expected 000000", bus.ovf); end
    n_checks++;
    if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
  endtask

  // Called with init just released; pushes (some against full) must be ignored.
  task automatic test_startup(input string tag);
    logic       exp_rst;
    logic       exp_rdy;
    init = 1'b0;
    bus.ff_ = 6'h30;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_rst = (k >= 4);
      exp_rdy = (k >= 8);
      n_checks++;
      if (bus.fifo_rst_ !== exp_rst) begin n_fail++; $display("FAIL %s_fifo_rst_ cyc%0d: got %b expected %b", tag, k, bus.fifo_rst_, exp_rst); end
      n_checks++;
      if (bus.ready !== exp_rdy) begin n_fail++; $display("FAIL %s_ready cyc%0d: got %b expected %b", tag, k, bus.ready, exp_rdy); end
      n_checks++;
      if (bus.wren_ !== 6'h3F) begin n_fail++; $display("FAIL %s_wren_ cyc%0d: got %b expected 111111", tag, k, bus.wren_); end
      n_checks++;
      if (bus.drop_cnt !== 8'd0 || bus.ovf !== 6'h00) begin n_fail++; $display("FAIL %s_no_drop cyc%0d: got cnt %0d ovf %b expected 0", tag, k, bus.drop_cnt, bus.ovf); end
    end
    bus.push = 6'h00;
    bus.ff_  = 6'h3F;
  endtask

  task automatic test_write();
    logic [5:0] exp;
    bus.ff_ = 6'h3F;
    bus.push = 6'b000101;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) bus.push = 6'h00;
      exp = (k <= 3) ? 6'b111010 : 6'h3F;
      n_checks++;
      if (bus.wren_ !== exp) begin n_fail++; $display("FAIL write_wren_ cyc%0d: got %b expected %b", k, bus.wren_, exp); end
    end
  endtask

  task automatic test_drop();
    bus.ff_ = 6'b110111;
    bus.push = 6'h3F;
    step();
    n_checks++;
    if (bus.wren_ !== 6'b001000) begin n_fail++; $display("FAIL drop_wren_: got %b expected 001000", bus.wren_); end
    n_checks++;
    if (bus.ovf !== 6'b001000) begin n_fail++; $display("FAIL drop_ovf: got %b expected 001000", bus.ovf); end
    n_checks++;
    if (bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 1", bus.drop_cnt); end
    bus.push = 6'h00; bus.ff_ = 6'h3F;
    step();
    n_checks++;
    if (bus.wren_ !== 6'h3F || bus.ovf !== 6'b001000 || bus.drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL drop_hold: got wren_ %b ovf %b cnt %0d expected 111111 001000 1", bus.wren_, bus.ovf, bus.drop_cnt);
    end
  endtask

  // Full asserting during the wren_ cycle, and full on an idle channel, change nothing.
  task automatic test_independence();
    bus.push = 6'b000010; bus.ff_ = 6'h3F;
    step();
    n_checks++;
    if (bus.wren_ !== 6'b111101) begin n_fail++; $display("FAIL indep_wren_a: got %b expected 111101", bus.wren_); end
    bus.push = 6'b000001; bus.ff_ = 6'b111001;
    step();
    n_checks++;
    if (bus.wren_ !== 6'b111110) begin n_fail++; $display("FAIL indep_wren_b: got %b expected 111110", bus.wren_); end
    n_checks++;
    if (bus.ovf !== 6'b001000 || bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL indep_acct: got ovf %b cnt %0d expected 001000 1", bus.ovf, bus.drop_cnt); end
    bus.push = 6'h00; bus.ff_ = 6'h3F;
    step();
  endtask

  task automatic test_saturate_clear();
    bus.ff_ = 6'h00;
    bus.push = 6'h3F;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (bus.drop_cnt !== 8'd7) begin n_fail++; $display("FAIL sat_cnt_first: got %0d expected 7", bus.drop_cnt); end
      end
      if (k == 42) begin
        n_checks++;
        if (bus.drop_cnt !== 8'd253) begin n_fail++; $display("FAIL sat_cnt_edge: got %0d expected 253", bus.drop_cnt); end
      end
      if (k == 43) begin
        n_checks++;
        if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_clip: got %0d expected 255", bus.drop_cnt); end
      end
    end
    n_checks++;
    if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_hold: got %0d expected 255", bus.drop_cnt); end
    n_checks++;
    if (bus.ovf !== 6'h3F) begin n_fail++; $display("FAIL sat_ovf: got %b expected 111111", bus.ovf); end
    bus.clr_ovf = 1'b1; bus.push = 6'b000011;
    step();
    n_checks++;
    if (bus.ovf !== 6'b000011) begin n_fail++; $display("FAIL clr_drop_ovf: got %b expected 000011", bus.ovf); end
    n_checks++;
    if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL clr_drop_cnt: got %0d expected 2", bus.drop_cnt); end
    bus.push = 6'h00;
    step();
    n_checks++;
    if (bus.ovf !== 6'h00 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_only: got ovf %b cnt %0d expected 000000 0", bus.ovf, bus.drop_cnt); end
    bus.clr_ovf = 1'b0; bus.ff_ = 6'h3F;
  endtask

  task automatic test_init_abort();
    bus.push = 6'b000001; bus.ff_ = 6'b111110;
    step();
    n_checks++;
    if (bus.ovf !== 6'b000001 || bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_pre: got ovf %b cnt %0d expected 000001 1", bus.ovf, bus.drop_cnt); end
    bus.push = 6'b000010; bus.ff_ = 6'h3F;
    step();
    step();
    n_checks++;
    if (bus.wren_ !== 6'b111101) begin n_fail++; $display("FAIL abort_burst: got %b expected 111101", bus.wren_); end
    init = 1'b1;
    step();
    n_checks++;
    if (bus.wren_ !== 6'h3F) begin n_fail++; $display("FAIL abort_wren_: got %b expected 111111", bus.wren_); end
    n_checks++;
    if (bus.fifo_rst_ !== 1'b0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got fifo_rst_ %b ready %b expected 0 0", bus.fifo_rst_, bus.ready); end
    n_checks++;
    if (bus.ovf !== 6'h00 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL abort_acct: got ovf %b cnt %0d expected 000000 0", bus.ovf, bus.drop_cnt); end
    bus.push = 6'h3F;
    test_startup("restart");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init = 1'b1;
    bus.push = 6'h00; bus.ff_ = 6'h3F; bus.clr_ovf = 1'b0;
    test_reset();
    bus.push = 6'h3F;
    test_startup("startup");
    test_write();
    test_drop();
    test_independence();
    test_saturate_clear();
    test_init_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
